// File: rtl/fpu_multicycle_ctrl.sv
// EX-stage sequencer for multi-cycle RV32F operations: starts the FPU, stalls the
// pipeline for the operation latency and emits a tagged one-cycle result strobe.
module fpu_multicycle_ctrl #(
  parameter int unsigned ADD_LATENCY  = 3,
  parameter int unsigned MUL_LATENCY  = 3,
  parameter int unsigned FMA_LATENCY  = 4,
  parameter int unsigned DIV_LATENCY  = 12,
  parameter int unsigned SQRT_LATENCY = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ISSUE_VALID,
  input  logic [4:0]  FPU_SELECT,
  input  logic [4:0]  RD,
  input  logic        FREG_WRITE_EN,
  input  logic        FLUSH,
  output logic        FPU_START,
  output logic        FPU_ABORT,
  output logic        STALL,
  output logic        RESULT_VALID,
  output logic [4:0]  RESULT_RD,
  output logic        RESULT_FREG,
  output logic [4:0]  BUSY_RD,
  output logic        BUSY,
  output logic [31:0] STALL_COUNT
);

  localparam logic [5:0] ADD_L  = 6'(ADD_LATENCY);
  localparam logic [5:0] MUL_L  = 6'(MUL_LATENCY);
  localparam logic [5:0] FMA_L  = 6'(FMA_LATENCY);
  localparam logic [5:0] DIV_L  = 6'(DIV_LATENCY);
  localparam logic [5:0] SQRT_L = 6'(SQRT_LATENCY);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state, state_next;
  logic [5:0] counter, counter_next;
  logic [5:0] lat;
  logic       accept;

  always_comb begin
    lat = 6'd1;
    case (FPU_SELECT)
      5'b00001, 5'b00010:                         lat = ADD_L;
      5'b00011:                                   lat = MUL_L;
      5'b01110, 5'b01111, 5'b10000, 5'b10001:     lat = FMA_L;
      5'b00100:                                   lat = DIV_L;
      5'b01101:                                   lat = SQRT_L;
      default:                                    lat = 6'd1;
    endcase
  end

  // A flush or an active reset kills the issue before it reaches the FPU.
  assign accept = (state == IDLE) && RESET && ISSUE_VALID && (lat > 6'd1) && !FLUSH;

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    state_next   = state;
    counter_next = counter;
    FPU_START    = 1'b0;
    STALL        = 1'b0;
    RESULT_VALID = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          FPU_START    = 1'b1;
          STALL        = 1'b1;
          counter_next = lat - 6'd1;
          state_next   = (lat == 6'd2) ? DONE : RUN;
        end
      end
      RUN: begin
        if (FLUSH) begin
          state_next = IDLE;
        end else begin
          // counter holds cycles left until the instruction leaves EX, so the
          // last stall cycle is the one where it is about to reach 1.
          STALL        = 1'b1;
          counter_next = counter - 6'd1;
          if (counter_next == 6'd1) state_next = DONE;
        end
      end
      DONE: begin
        RESULT_VALID = !FLUSH;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state       <= IDLE;
      counter     <= 6'd0;
      BUSY_RD     <= 5'd0;
      RESULT_FREG <= 1'b0;
      BUSY        <= 1'b0;
      FPU_ABORT   <= 1'b0;
      STALL_COUNT <= 32'd0;
    end else begin
      state     <= state_next;
      counter   <= counter_next;
      BUSY      <= (state_next != IDLE);
      FPU_ABORT <= FLUSH && (state != IDLE);
      if (accept) begin
        BUSY_RD     <= RD;
        RESULT_FREG <= FREG_WRITE_EN;
      end
      if (STALL && (STALL_COUNT != 32'hFFFF_FFFF)) STALL_COUNT <= STALL_COUNT + 32'd1;
    end
  end

  assign RESULT_RD = BUSY_RD;

endmodule

// File: tb/tb_fpu_multicycle_ctrl.sv
// Randomized and directed bench for fpu_multicycle_ctrl against an operation-age
// reference model (issue cycle, latency, flush and reset events).
module tb_fpu_multicycle_ctrl;

  localparam int ADD_LAT  = 3;
  localparam int MUL_LAT  = 3;
  localparam int FMA_LAT  = 4;
  localparam int DIV_LAT  = 12;
  localparam int SQRT_LAT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  fpu_select = 5'd0;
  logic [4:0]  rd = 5'd0;
  logic        freg_write_en = 1'b0;
  logic        flush = 1'b0;
  logic        fpu_start, fpu_abort, stall, result_valid, result_freg, busy;
  logic [4:0]  result_rd, busy_rd;
  logic [31:0] stall_count;

  fpu_multicycle_ctrl #(
    .ADD_LATENCY(ADD_LAT), .MUL_LATENCY(MUL_LAT), .FMA_LATENCY(FMA_LAT),
    .DIV_LATENCY(DIV_LAT), .SQRT_LATENCY(SQRT_LAT)
  ) dut (
    .CLK(clk), .RESET(rst), .ISSUE_VALID(issue_valid), .FPU_SELECT(fpu_select),
    .RD(rd), .FREG_WRITE_EN(freg_write_en), .FLUSH(flush),
    .FPU_START(fpu_start), .FPU_ABORT(fpu_abort), .STALL(stall),
    .RESULT_VALID(result_valid), .RESULT_RD(result_rd), .RESULT_FREG(result_freg),
    .BUSY_RD(busy_rd), .BUSY(busy), .STALL_COUNT(stall_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: at most one operation, described by its age since issue.
  bit          m_active;
  int          m_age, m_lat;
  logic [4:0]  m_rd;
  logic        m_freg, m_abort;
  logic [31:0] m_cnt;

  // Values observed in the most recent cycle, for directed scenario checks.
  logic obs_start, obs_stall, obs_rv, obs_abort, obs_busy;

  function automatic int lat_of(input logic [4:0] sel);
    case (sel)
      5'b00001, 5'b00010:                     return ADD_LAT;
      5'b00011:                               return MUL_LAT;
      5'b01110, 5'b01111, 5'b10000, 5'b10001: return FMA_LAT;
      5'b00100:                               return DIV_LAT;
      5'b01101:                               return SQRT_LAT;
      default:                                return 1;
    endcase
  endfunction

  task automatic model_clear();
    m_active = 0; m_age = 0; m_lat = 0; m_rd = 0; m_freg = 0; m_abort = 0; m_cnt = 0;
  endtask

  // One clock cycle: drive inputs, compare every output mid-cycle, advance model.
  task automatic step(input logic iv, input logic [4:0] sel, input logic [4:0] r,
                      input logic fr, input logic fl, input logic rs);
    bit e_start, e_stall, e_rv, done;
    issue_valid = iv; fpu_select = sel; rd = r; freg_write_en = fr; flush = fl; rst = rs;
    @(negedge clk);
    done = m_active && (m_age == m_lat - 1);
    if (m_active) begin
      e_start = 0;
      e_stall = !done && !fl;
      e_rv    = done && !fl;
    end else begin
      e_start = rs && iv && (lat_of(sel) > 1) && !fl;
      e_stall = e_start;
      e_rv    = 0;
    end
    obs_start = fpu_start; obs_stall = stall; obs_rv = result_valid;
    obs_abort = fpu_abort; obs_busy = busy;
    checks += 6;
    if (fpu_start !== e_start) begin errors++; $display("FAIL start t=%0t: got %b want %b", $time, fpu_start, e_start); end
    if (stall !== e_stall) begin errors++; $display("FAIL stall t=%0t: got %b want %b", $time, stall, e_stall); end
    if (result_valid !== e_rv) begin errors++; $display("FAIL result_valid t=%0t: got %b want %b", $time, result_valid, e_rv); end
    if (busy !== m_active) begin errors++; $display("FAIL busy t=%0t: got %b want %b", $time, busy, m_active); end
    if (fpu_abort !== m_abort) begin errors++; $display("FAIL abort t=%0t: got %b want %b", $time, fpu_abort, m_abort); end
    if (stall_count !== m_cnt) begin errors++; $display("FAIL stall_count t=%0t: got %0d want %0d", $time, stall_count, m_cnt); end
    if (m_active) begin
      checks++;
      if (busy_rd !== m_rd) begin errors++; $display("FAIL busy_rd t=%0t: got %0d want %0d", $time, busy_rd, m_rd); end
    end
    if (e_rv) begin
      checks += 2;
      if (result_rd !== m_rd) begin errors++; $display("FAIL result_rd t=%0t: got %0d want %0d", $time, result_rd, m_rd); end
      if (result_freg !== m_freg) begin errors++; $display("FAIL result_freg t=%0t: got %b want %b", $time, result_freg, m_freg); end
    end
    @(posedge clk);
    if (!rs) begin
      model_clear();
    end else begin
      m_abort = m_active && fl;
      if (e_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (m_active) begin
        if (fl || done) m_active = 0;
        else m_age++;
      end else if (e_start) begin
        m_active = 1; m_age = 1; m_lat = lat_of(sel); m_rd = r; m_freg = fr;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    checks += 5;
    if ({fpu_abort, busy, result_freg} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {fpu_abort, busy, result_freg}); end
    if (busy_rd !== 5'd0) begin errors++; $display("FAIL reset_busy_rd: got %0d want 0", busy_rd); end
    if (result_rd !== 5'd0) begin errors++; $display("FAIL reset_result_rd: got %0d want 0", result_rd); end
    if (stall_count !== 32'd0) begin errors++; $display("FAIL reset_stall_count: got %0d want 0", stall_count); end
    if ({stall, fpu_start, result_valid} !== 3'b000) begin errors++; $display("FAIL reset_comb: got %b want 000", {stall, fpu_start, result_valid}); end
  endtask

  task automatic test_div();
    int n_stall = 0, n_start = 0, rv_cyc = -1;
    for (int c = 0; c < 13; c++) begin
      step(c < 12, 5'b00100, 5'd5, 1'b1, 0, 1);
      if (obs_stall) n_stall++;
      if (obs_start && c != 0) n_start++;
      if (obs_rv) rv_cyc = c;
    end
    checks += 4;
    if (n_stall !== 11) begin errors++; $display("FAIL div_stall_cycles: got %0d want 11", n_stall); end
    if (n_start !== 0) begin errors++; $display("FAIL div_extra_start: got %0d want 0", n_start); end
    if (rv_cyc !== 11) begin errors++; $display("FAIL div_result_cycle: got %0d want 11", rv_cyc); end
    if (stall_count !== 32'd11) begin errors++; $display("FAIL div_stall_count: got %0d want 11", stall_count); end
  endtask

  task automatic test_single_cycle();
    int seen = 0;
    for (int c = 0; c < 3; c++) begin
      step(1, 5'b00111, 5'd9, 1'b1, 0, 1);
      if (obs_stall || obs_start || obs_rv || obs_busy) seen++;
    end
    step(0, 0, 0, 0, 0, 1);
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL single_cycle_activity: got %0d want 0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] base = stall_count;
    int rv1 = -1, rv2 = -1, st2 = -1;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) step(1, 5'b01110, 5'd3, 1'b1, 0, 1);
      else       step(c < 7, 5'b00011, 5'd17, 1'b0, 0, 1);
      if (obs_rv && rv1 < 0) rv1 = c;
      else if (obs_rv) rv2 = c;
      if (obs_start && c > 0) st2 = c;
    end
    checks += 4;
    if (rv1 !== 3) begin errors++; $display("FAIL b2b_first_result: got %0d want 3", rv1); end
    if (st2 !== 4) begin errors++; $display("FAIL b2b_second_start: got %0d want 4", st2); end
    if (rv2 !== 6) begin errors++; $display("FAIL b2b_second_result: got %0d want 6", rv2); end
    if (stall_count - base !== 32'd5) begin errors++; $display("FAIL b2b_stall_delta: got %0d want 5", stall_count - base); end
  endtask

  task automatic test_flush();
    int rv_seen = 0;
    for (int c = 0; c < 7; c++) begin
      step(1, 5'b01101, 5'd12, 1'b1, c == 6, 1);
      if (obs_rv) rv_seen++;
    end
    step(1, 5'b00001, 5'd20, 1'b1, 0, 1);
    checks += 4;
    if (obs_abort !== 1'b1) begin errors++; $display("FAIL flush_abort: got %b want 1", obs_abort); end
    if (obs_busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", obs_busy); end
    if (obs_start !== 1'b1) begin errors++; $display("FAIL flush_restart: got %b want 1", obs_start); end
    if (rv_seen !== 0) begin errors++; $display("FAIL flush_result: got %0d want 0", rv_seen); end
    step(1, 5'b00001, 5'd20, 1'b1, 0, 1);
    step(1, 5'b00001, 5'd20, 1'b1, 0, 1);
    step(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_reset_mid_op();
    for (int c = 0; c < 5; c++) step(1, 5'b00100, 5'd7, 1'b1, 0, c != 4);
    step(0, 0, 0, 0, 0, 1);
    checks += 2;
    if ({fpu_start, fpu_abort, stall, result_valid, busy} !== 5'b0) begin errors++; $display("FAIL midreset_ctrl: got %b want 00000", {fpu_start, fpu_abort, stall, result_valid, busy}); end
    if ({busy_rd, result_freg, stall_count} !== 38'd0) begin errors++; $display("FAIL midreset_regs: got %0h want 0", {busy_rd, result_freg, stall_count}); end
  endtask

  task automatic test_random();
    logic [4:0] codes [10] = '{5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b01101,
                               5'b01110, 5'b01111, 5'b10000, 5'b10001, 5'b00111};
    logic [4:0] sel;
    for (int c = 0; c < 600; c++) begin
      sel = ($urandom_range(0, 7) == 0) ? 5'($urandom) : codes[$urandom_range(0, 9)];
      step($urandom_range(0, 3) != 0, sel, 5'($urandom), 1'($urandom),
           $urandom_range(0, 15) == 0, $urandom_range(0, 99) != 0);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_div();
    test_single_cycle();
    test_back_to_back();
    test_flush();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
